// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core control path.
// Sequencer state encoding, reset vector and bus byte-order helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    RESET_S,
    FETCH,
    EXEC1,
    EXEC2,
    HALTED
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  function automatic logic [31:0] byte_swap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2 sequencer for the MIPS core.
// Owns the shared memory bus and the instruction register.
module cpu_state_sequencer
  import cpu_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic [31:0] pc_address,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic        halt,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] instr,
  output logic        stall,
  output logic        active
);

  seq_state_t state;
  seq_state_t state_nx;

  logic [31:0] fetch_word;
  logic        data_req;

  assign fetch_word = SWAP_BYTES ? byte_swap32(readdata)
                                 : readdata;
  assign data_req   = data_read | data_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RESET_S;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr <= '0;
    end else if (state == FETCH && !waitrequest) begin
      instr <= fetch_word;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RESET_S: state_nx = FETCH;
      FETCH: begin
        if (!waitrequest) state_nx = EXEC1;
      end
      EXEC1: begin
        if (!(data_req && waitrequest)) state_nx = EXEC2;
      end
      EXEC2: state_nx = halt ? HALTED : FETCH;
      HALTED: state_nx = HALTED;
      default: state_nx = RESET_S;
    endcase
  end

  always_comb begin
    fetch       = 1'b0;
    exec1       = 1'b0;
    exec2       = 1'b0;
    bus_address = '0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    active      = 1'b0;
    case (state)
      FETCH: begin
        fetch       = 1'b1;
        bus_read    = 1'b1;
        bus_address = pc_address;
        active      = 1'b1;
      end
      EXEC1: begin
        exec1       = 1'b1;
        bus_address = data_address;
        // simultaneous read+write resolves to a write
        bus_read    = data_read & ~data_write;
        bus_write   = data_write;
        active      = 1'b1;
      end
      EXEC2: begin
        exec2  = 1'b1;
        active = 1'b1;
      end
      default: begin
        fetch = 1'b0;
      end
    endcase
  end

  assign stall = (bus_read | bus_write) & waitrequest;

endmodule

// File: doc/cpu_state_sequencer.md
# cpu_state_sequencer

Multi-cycle control sequencer for the MIPS CPU core. Generates the one-hot FETCH/EXEC1/EXEC2 phase strobes consumed by the PC and datapath. Arbitrates the single memory bus between instruction fetch and data access, and stalls on `waitrequest`. Latches the fetched instruction into the instruction register, and parks the core in HALTED when the PC reports a halt.

## Interface
- `SWAP_BYTES`, default 1: 1 = `instr` is `readdata` byte-reversed (bus is little-endian, decode expects big-endian word); 0 = pass-through.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `waitrequest`  in  1  bus stall; the current request must be held while high
- `readdata`  in  32  bus read data
- `pc_address`  in  32  fetch address from the PC block
- `data_address`  in  32  load/store address from the ALU
- `data_read`  in  1  current instruction performs a load (valid in EXEC1)
- `data_write`  in  1  current instruction performs a store (valid in EXEC1)
- `halt`  in  1  from the PC; the fetched address was 0
- `fetch`, `exec1`, `exec2`  out  1 each  one-hot phase strobes
- `bus_address`  out  32  memory address
- `bus_read`  out  1  memory read request
- `bus_write`  out  1  memory write request
- `instr`  out  32  instruction register
- `stall`  out  1  high whenever a bus request is held by `waitrequest`
- `active`  out  1  high from the first FETCH until HALTED

## Operation
- States: RESET_S, FETCH, EXEC1, EXEC2, HALTED. Encoding is held in the shared package.
- RESET_S:
  - Entered on any clock edge with `reset`=0, from any state, aborting any bus request in flight.
  - All outputs are 0, including `instr`=0. Next state is FETCH once `reset`=1.
- FETCH:
  - `fetch`=1, `bus_read`=1, `bus_address`=`pc_address`, `active`=1.
  - `waitrequest`=1: stay in FETCH and hold the request.
  - `waitrequest`=0: latch `instr` (swapped per `SWAP_BYTES`) at the edge and go to EXEC1.
- EXEC1:
  - `exec1`=1, `bus_address`=`data_address`, `bus_read`=`data_read`, `bus_write`=`data_write`.
  - With a request active and `waitrequest`=1: stay in EXEC1.
  - Otherwise go to EXEC2.
  - `data_read` and `data_write` both high is illegal. The block treats it as a write only.
- EXEC2:
  - `exec2`=1, no bus request. The datapath consumes `readdata` here.
  - `halt`=1 sampled at the edge: go to HALTED. Otherwise go to FETCH.
- HALTED:
  - Strobes all 0, `active`=0, no bus request, `instr` held.
  - Exit only via reset.
- `stall` = (`bus_read` | `bus_write`) & `waitrequest`.
- `instr` changes only on the FETCH→EXEC1 transition.

## Timing
- All outputs are registered state decodes or combinational functions of state and inputs. No combinational path runs from `waitrequest` to the phase strobes.
- Minimum instruction time is 3 cycles (FETCH, EXEC1, EXEC2). Each `waitrequest` cycle adds one cycle to its phase.
- Exactly one of `fetch`/`exec1`/`exec2` is high in FETCH/EXEC1/EXEC2. None is high in RESET_S or HALTED.
- `reset` low for one edge mid-EXEC1 with a pending store: the next cycle has `bus_write`=0 and state RESET_S.
- `halt` is ignored outside EXEC2.
- `waitrequest` is ignored when no request is driven.

## Structure
- Shared package `cpu_pkg`: `seq_state_t` enum (RESET_S, FETCH, EXEC1, EXEC2, HALTED) and constant `RESET_VECTOR`=32'hBFC00000. The PC uses `RESET_VECTOR` as its reset address.
- Single module, no sub-modules. `byte_swap32` is a function in `cpu_pkg`.

## Test plan
- Release reset, `waitrequest`=0, `pc_address`=32'hBFC00000, `readdata`=32'h78563412 → FETCH on the first cycle after release, `bus_read`=1, `bus_address`=32'hBFC00000. Then `instr`=32'h12345678 in EXEC1 (`SWAP_BYTES`=1). Then `fetch`→`exec1`→`exec2`→`fetch` repeats with period 3.
- `waitrequest`=1 for 2 cycles in FETCH → `fetch` held 3 cycles, `stall`=1 for 2 of them. `instr` is latched only after `waitrequest` falls.
- Store in EXEC1: `data_write`=1, `data_address`=32'h00001004, `waitrequest`=1 for 1 cycle → `bus_write`=1 with `bus_address`=32'h00001004 for 2 cycles, then EXEC2.
- Load with `data_read`=1, no wait → `bus_read`=1 in EXEC1 only. EXEC2 has `bus_read`=0.
- `halt`=1 in EXEC2 → HALTED: `active`=0, all strobes 0, no bus activity for 20 cycles. Reset low, then high → FETCH.
- `reset`=0 asserted during a stalled EXEC1 store → next cycle all outputs 0 and `instr`=0. Sequencing restarts cleanly after release.
